hvac_thermostat_ctrl: RTL and testbench

HVAC_THERMOSTAT_CTRL -- requirements
Module: hvac_thermostat_ctrl

---
 rtl/hvac_thermostat_ctrl.sv | 171 +++++++++++++++++
 tb/tb_hvac_thermostat_ctrl.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/hvac_thermostat_ctrl.sv
// Hysteresis thermostat that commands an HVAC unit with dwell limiting and an ack handshake.
// Define HVAC_ACK_CHECK_EN to check unit status acks (timeout, retry, FAULT); otherwise acks are assumed.
module hvac_thermostat_ctrl #(
    parameter int unsigned HYST        = 2,
    parameter int unsigned MIN_DWELL   = 16,
    parameter int unsigned ACK_TIMEOUT = 4,
    parameter int unsigned MAX_RETRY   = 3
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       enable,
    input  logic [7:0] temp,
    input  logic [7:0] setpoint,
    input  logic       st_disp,
    input  logic       st_heat,
    input  logic       st_cool,
    input  logic       st_off,
    output logic       cmd_on,
    output logic       cmd_heat,
    output logic       cmd_cool,
    output logic       cmd_off,
    output logic [1:0] mode_o,
    output logic       busy,
    output logic       fault
);
    typedef enum logic [1:0] {ModeOff = 2'b00, ModeIdle = 2'b01, ModeHeat = 2'b10,
                              ModeCool = 2'b11} mode_e;
    typedef enum logic [1:0] {StEval, StIssue, StWaitAck, StFault} state_e;

    localparam int unsigned DwellW = (MIN_DWELL > 0) ? $clog2(MIN_DWELL + 1) : 1;
    localparam logic [8:0] Hyst9 = 9'(HYST);

    state_e            state_q, state_d;
    mode_e             mode_q, mode_d, tgt_q, tgt_d, target;
    logic [DwellW-1:0] dwell_q, dwell_d;
    logic [3:0]        cmd_q, cmd_d;  // {on, heat, cool, off}
    logic              busy_q;
    logic              ack_match;
    logic [8:0]        sp9, sum9, lo9, hi9;

    assign sp9  = {1'b0, setpoint};
    assign sum9 = sp9 + Hyst9;
    assign lo9  = (sp9 < Hyst9) ? 9'd0 : sp9 - Hyst9;
    assign hi9  = (sum9 > 9'd255) ? 9'd255 : sum9;

    always_comb begin
        target = mode_q;
        if (!enable)                                     target = ModeOff;
        else if ({1'b0, temp} < lo9)                     target = ModeHeat;
        else if ({1'b0, temp} > hi9)                     target = ModeCool;
        else if (mode_q == ModeHeat && temp >= setpoint) target = ModeIdle;
        else if (mode_q == ModeCool && temp <= setpoint) target = ModeIdle;
        else if (mode_q == ModeOff)                      target = ModeIdle;
    end

`ifdef HVAC_ACK_CHECK_EN
    localparam int unsigned WaitW  = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam int unsigned RetryW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    logic [WaitW-1:0]  wait_q, wait_d;
    logic [RetryW-1:0] retry_q, retry_d;
    logic              fault_q;

    always_comb begin
        unique case (tgt_q)
            ModeOff:  ack_match = st_off;
            ModeIdle: ack_match = st_disp & ~st_heat & ~st_cool;
            ModeHeat: ack_match = st_heat;
            ModeCool: ack_match = st_cool;
        endcase
    end

    assign fault = fault_q;
`else
    logic unused_status;
    assign unused_status = ^{st_disp, st_heat, st_cool, st_off};
    assign ack_match     = 1'b1;
    assign fault         = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        tgt_d   = tgt_q;
        dwell_d = (dwell_q != '0) ? dwell_q - DwellW'(1) : '0;
`ifdef HVAC_ACK_CHECK_EN
        wait_d  = wait_q;
        retry_d = retry_q;
`endif
        unique case (state_q)
            StEval: begin
                // Turning off must never be delayed by the dwell window
                if (target != mode_q && (dwell_q == '0 || target == ModeOff)) begin
                    state_d = StIssue;
                    tgt_d   = target;
                end
            end
            StIssue: begin
                state_d = StWaitAck;
`ifdef HVAC_ACK_CHECK_EN
                wait_d  = '0;
`endif
            end
            StWaitAck: begin
                if (ack_match) begin
                    mode_d  = tgt_q;
                    dwell_d = DwellW'(MIN_DWELL);
                    state_d = StEval;
`ifdef HVAC_ACK_CHECK_EN
                    retry_d = '0;
                end else if (wait_q == WaitW'(ACK_TIMEOUT - 1)) begin
                    if (retry_q == RetryW'(MAX_RETRY)) begin
                        state_d = StFault;
                    end else begin
                        retry_d = retry_q + RetryW'(1);
                        state_d = StIssue;
                    end
                end else begin
                    wait_d = wait_q + WaitW'(1);
`endif
                end
            end
            StFault: state_d = StFault;
        endcase
    end

    always_comb begin
        cmd_d = '0;
        if (state_d == StIssue) begin
            unique case (tgt_d)
                ModeOff:  cmd_d = 4'b0001;
                ModeIdle: cmd_d = 4'b1000;
                ModeHeat: cmd_d = 4'b1100;
                ModeCool: cmd_d = 4'b1010;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= StEval;
            mode_q  <= ModeOff;
            tgt_q   <= ModeOff;
            dwell_q <= '0;
            cmd_q   <= '0;
            busy_q  <= 1'b0;
`ifdef HVAC_ACK_CHECK_EN
            wait_q  <= '0;
            retry_q <= '0;
            fault_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            tgt_q   <= tgt_d;
            dwell_q <= dwell_d;
            cmd_q   <= cmd_d;
            busy_q  <= (state_d == StIssue) || (state_d == StWaitAck);
`ifdef HVAC_ACK_CHECK_EN
            wait_q  <= wait_d;
            retry_q <= retry_d;
            fault_q <= (state_d == StFault);
`endif
        end
    end

    assign {cmd_on, cmd_heat, cmd_cool, cmd_off} = cmd_q;
    assign mode_o = mode_q;
    assign busy   = busy_q;

endmodule

// File: tb/tb_hvac_thermostat_ctrl.sv
// Directed self-checking bench for hvac_thermostat_ctrl with a status responder that mirrors commands.
module tb_hvac_thermostat_ctrl;
    logic       clk = 1'b0;
    logic       reset_n, enable;
    logic [7:0] temp, setpoint;
    logic       st_disp, st_heat, st_cool, st_off;
    logic       cmd_on, cmd_heat, cmd_cool, cmd_off;
    logic [1:0] mode_o;
    logic       busy, fault;
    logic [3:0] cmds;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    int unsigned cyc = 0;
    int unsigned pulse_cnt = 0;
    int unsigned first_pc = 0;
    int unsigned last_pc = 0;
    bit          resp_en = 1'b0;

    hvac_thermostat_ctrl #(
        .HYST       (2),
        .MIN_DWELL  (16),
        .ACK_TIMEOUT(4),
        .MAX_RETRY  (3)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .enable  (enable),
        .temp    (temp),
        .setpoint(setpoint),
        .st_disp (st_disp),
        .st_heat (st_heat),
        .st_cool (st_cool),
        .st_off  (st_off),
        .cmd_on  (cmd_on),
        .cmd_heat(cmd_heat),
        .cmd_cool(cmd_cool),
        .cmd_off (cmd_off),
        .mode_o  (mode_o),
        .busy    (busy),
        .fault   (fault)
    );

    assign cmds = {cmd_on, cmd_heat, cmd_cool, cmd_off};

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance n cycles; sample 1 time unit after each edge, count command cycles, run responder.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            cyc++;
            if (cmds != 4'b0000) begin
                pulse_cnt++;
                if (pulse_cnt == 1) first_pc = cyc;
                last_pc = cyc;
            end
            if (resp_en) begin
                if (cmd_off) begin
                    st_off = 1'b1; st_disp = 1'b0; st_heat = 1'b0; st_cool = 1'b0;
                end else if (cmd_on) begin
                    st_off = 1'b0; st_disp = 1'b1; st_heat = cmd_heat; st_cool = cmd_cool;
                end
            end
        end
    endtask

    initial begin
        reset_n = 1'b0; enable = 1'b0; temp = 8'd0; setpoint = 8'd0;
        st_disp = 1'b0; st_heat = 1'b0; st_cool = 1'b0; st_off = 1'b0;
        step(2);
        check("rst_mode", 32'(mode_o), 32'd0);
        check("rst_cmds", 32'(cmds), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_fault", 32'(fault), 32'd0);

        // Cold start: heat request issued immediately, acked by responder
        reset_n = 1'b1; enable = 1'b1; setpoint = 8'd20; temp = 8'd15; resp_en = 1'b1;
        step(1);
        check("heat_cmd", 32'(cmds), 32'hC);
        check("heat_busy_issue", 32'(busy), 32'd1);
        step(1);
        check("heat_cmd_drop", 32'(cmds), 32'd0);
        check("heat_busy_wait", 32'(busy), 32'd1);
        check("heat_mode_pending", 32'(mode_o), 32'd0);
        step(1);
        check("heat_mode", 32'(mode_o), 32'd2);
        check("heat_busy_done", 32'(busy), 32'd0);

        // Reaching setpoint goes IDLE, but only after the dwell window
        temp = 8'd20; pulse_cnt = 0;
        step(16);
        check("idle_dwell_quiet", pulse_cnt, 0);
        step(1);
        check("idle_cmd", 32'(cmds), 32'h8);
        step(2);
        check("idle_mode", 32'(mode_o), 32'd1);

        // Inside the band: no command; saturated low threshold stops a wrap-around HEAT
        temp = 8'd18; pulse_cnt = 0;
        step(20);
        check("band_edge_quiet", pulse_cnt, 0);
        setpoint = 8'd1; temp = 8'd0;
        step(5);
        check("lo_sat_quiet", pulse_cnt, 0);
        check("lo_sat_mode", 32'(mode_o), 32'd1);
        setpoint = 8'd20; temp = 8'd17;
        step(1);
        check("below_band_cmd", 32'(cmds), 32'hC);
        step(2);
        check("below_band_mode", 32'(mode_o), 32'd2);

        // Disable during dwell: OFF bypasses dwell
        pulse_cnt = 0;
        step(3);
        check("hold_heat_quiet", pulse_cnt, 0);
        enable = 1'b0;
        step(1);
        check("off_cmd", 32'(cmds), 32'h1);
        step(2);
        check("off_mode", 32'(mode_o), 32'd0);
        check("off_busy", 32'(busy), 32'd0);

        // Above band from OFF: COOL after dwell
        enable = 1'b1; temp = 8'd30; pulse_cnt = 0;
        step(16);
        check("cool_dwell_quiet", pulse_cnt, 0);
        step(1);
        check("cool_cmd", 32'(cmds), 32'hA);
        step(2);
        check("cool_mode", 32'(mode_o), 32'd3);

        // Reset in the middle of WAIT_ACK
        resp_en = 1'b0;
        st_disp = 1'b0; st_heat = 1'b0; st_cool = 1'b0; st_off = 1'b0;
        temp = 8'd15;
        step(16);
        step(1);
        check("mid_cmd", 32'(cmds), 32'hC);
        step(1);
        check("mid_busy", 32'(busy), 32'd1);
        reset_n = 1'b0;
        step(1);
        check("mid_rst_mode", 32'(mode_o), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_cmds", 32'(cmds), 32'd0);
        check("mid_rst_fault", 32'(fault), 32'd0);
        pulse_cnt = 0;
        step(1);
        check("mid_rst_hold_quiet", pulse_cnt, 0);

        // Silent unit after reset release
        reset_n = 1'b1;
        step(1);
        check("retry_first_cmd", 32'(cmds), 32'hC);
`ifdef HVAC_ACK_CHECK_EN
        step(19);
        check("retry_no_fault_yet", 32'(fault), 32'd0);
        check("retry_busy", 32'(busy), 32'd1);
        step(1);
        check("fault_set", 32'(fault), 32'd1);
        check("fault_busy", 32'(busy), 32'd0);
        check("fault_pulses", pulse_cnt, 4);
        check("fault_spacing", last_pc - first_pc, 15);
        step(10);
        check("fault_pulses_hold", pulse_cnt, 4);
        check("fault_cmds", 32'(cmds), 32'd0);
        check("fault_sticky", 32'(fault), 32'd1);
`else
        step(2);
        check("noack_mode", 32'(mode_o), 32'd2);
        step(20);
        check("noack_pulses", pulse_cnt, 1);
        check("noack_fault", 32'(fault), 32'd0);
`endif
        reset_n = 1'b0;
        step(1);
        check("final_rst_fault", 32'(fault), 32'd0);
        check("final_rst_mode", 32'(mode_o), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
